// File: rtl/ioctl_rom_sequencer.sv
// Paces the HPS ioctl ROM download into the core's ROM write ports and holds the core in reset until it settles.
// Optional build macro DL_CHECKSUM_EN adds a running checksum that must match EXPECTED_SUM for rom_ok.
module ioctl_rom_sequencer #(
    parameter int         CPU_ROM_BYTES = 61440,
    parameter int         SND_ROM_BYTES = 8192,
    parameter int         WR_SPACING    = 4,
    parameter int         RESET_HOLD    = 16,
    parameter logic [7:0] EXPECTED_SUM  = 8'h00
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr_cpu,
    output logic        dl_wr_snd,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        rom_err,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [24:0] CPU_LIMIT      = 25'(CPU_ROM_BYTES);
    localparam logic [24:0] SND_LIMIT      = 25'(SND_ROM_BYTES);
    localparam logic [16:0] CPU_TARGET     = 17'(CPU_ROM_BYTES);
    localparam logic [16:0] SND_TARGET     = 17'(SND_ROM_BYTES);
    localparam logic [3:0]  SPACING_RELOAD = 4'(WR_SPACING - 1);
    localparam logic [15:0] HOLD_RELOAD    = 16'(RESET_HOLD);

    state_t        state_q, state_d;
    logic [33:0]   mem_q [2];
    logic [33:0]   mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          wait_q, wait_d;
    logic [3:0]    timer_q, timer_d;
    logic [15:0]   hold_q, hold_d;
    logic [24:0]   dl_addr_q, dl_addr_d;
    logic [7:0]    dl_data_q, dl_data_d;
    logic          wr_cpu_q, wr_cpu_d;
    logic          wr_snd_q, wr_snd_d;
    logic          core_reset_q, core_reset_d;
    logic          rom_ok_q, rom_ok_d;
    logic          rom_err_q, rom_err_d;
    logic [16:0]   cpu_count_q, cpu_count_d;
    logic [16:0]   snd_count_q, snd_count_d;

    logic          enter_load;
    logic          finish;
    logic          wr_valid;
    logic          is_cpu;
    logic          is_snd;
    logic          in_range;
    logic          range_err;
    logic          drop_err;
    logic          push;
    logic          pop;
    logic [33:0]   head;
    logic          sum_ok;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ioctl_download) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ioctl_download) begin
                    state_d = ST_LOAD;
                end else if (count_q == 2'd0) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_RELOAD;
                end
            end
            ST_HOLD: begin
                if (ioctl_download) begin
                    state_d = ST_LOAD;
                end else if (hold_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            ST_RUN: begin
                if (ioctl_download) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_load   = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign finish       = (state_q == ST_DRAIN) && (state_d == ST_HOLD);
    assign core_reset_d = (state_d != ST_RUN);

    // Only indices 0 and 1 are routable; range and overflow faults are recorded, foreign indices are not.
    always_comb begin
        wr_valid  = (state_q == ST_LOAD) && ioctl_wr;
        is_cpu    = (ioctl_index == 8'd0);
        is_snd    = (ioctl_index == 8'd1);
        in_range  = is_snd ? (ioctl_addr < SND_LIMIT) : (ioctl_addr < CPU_LIMIT);
        range_err = wr_valid && (is_cpu || is_snd) && !in_range;
        drop_err  = wr_valid && (is_cpu || is_snd) && in_range && (count_q == 2'd2);
        push      = wr_valid && (is_cpu || is_snd) && in_range && (count_q != 2'd2);
        pop       = (count_q != 2'd0) && (timer_q == 4'd0);
        head      = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        if (push) mem_d[wr_ptr_q] = {is_snd, ioctl_addr, ioctl_data};
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Wait goes high on the first queued entry; the second slot covers the HPS reaction delay.
        wait_d = (count_d != 2'd0);
    end

    always_comb begin
        dl_addr_d   = dl_addr_q;
        dl_data_d   = dl_data_q;
        wr_cpu_d    = 1'b0;
        wr_snd_d    = 1'b0;
        timer_d     = timer_q;
        cpu_count_d = cpu_count_q;
        snd_count_d = snd_count_q;
        if (pop) begin
            dl_addr_d = head[32:8];
            dl_data_d = head[7:0];
            wr_snd_d  = head[33];
            wr_cpu_d  = !head[33];
            timer_d   = SPACING_RELOAD;
        end else if (timer_q != 4'd0) begin
            timer_d = timer_q - 4'd1;
        end
        if (enter_load) begin
            cpu_count_d = '0;
            snd_count_d = '0;
        end else if (pop) begin
            if (!head[33] && (cpu_count_q != '1)) cpu_count_d = cpu_count_q + 17'd1;
            if (head[33] && (snd_count_q != '1))  snd_count_d = snd_count_q + 17'd1;
        end
    end

    always_comb begin
        rom_ok_d  = rom_ok_q;
        rom_err_d = rom_err_q;
        if (enter_load) begin
            rom_ok_d  = 1'b0;
            rom_err_d = 1'b0;
        end else begin
            if (range_err || drop_err) rom_err_d = 1'b1;
            if (finish) begin
                rom_ok_d = !rom_err_q && (cpu_count_q == CPU_TARGET)
                           && (snd_count_q == SND_TARGET) && sum_ok;
                if (!sum_ok) rom_err_d = 1'b1;
            end
        end
    end

`ifdef DL_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (enter_load) begin
            sum_d = 8'h00;
        end else if (pop) begin
            sum_d = sum_q + head[7:0];
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_ok   = (sum_q == EXPECTED_SUM);
    assign checksum = sum_q;
`else
    logic unused_expected_sum;

    assign unused_expected_sum = ^EXPECTED_SUM;
    assign sum_ok              = 1'b1;
    assign checksum            = 8'h00;
`endif

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            wait_q       <= 1'b0;
            timer_q      <= 4'd0;
            hold_q       <= 16'd0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            wr_cpu_q     <= 1'b0;
            wr_snd_q     <= 1'b0;
            core_reset_q <= 1'b1;
            rom_ok_q     <= 1'b0;
            rom_err_q    <= 1'b0;
            cpu_count_q  <= '0;
            snd_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            timer_q      <= timer_d;
            hold_q       <= hold_d;
            dl_addr_q    <= dl_addr_d;
            dl_data_q    <= dl_data_d;
            wr_cpu_q     <= wr_cpu_d;
            wr_snd_q     <= wr_snd_d;
            core_reset_q <= core_reset_d;
            rom_ok_q     <= rom_ok_d;
            rom_err_q    <= rom_err_d;
            cpu_count_q  <= cpu_count_d;
            snd_count_q  <= snd_count_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;
    assign dl_wr_cpu  = wr_cpu_q;
    assign dl_wr_snd  = wr_snd_q;
    assign core_reset = core_reset_q;
    assign rom_ok     = rom_ok_q;
    assign rom_err    = rom_err_q;

endmodule

// File: tb/tb_ioctl_rom_sequencer.sv
// Directed bench for ioctl_rom_sequencer using reduced ROM sizes so complete downloads stay short.
// A strobe scoreboard checks order, routing and spacing of every output write.
module tb_ioctl_rom_sequencer;

    localparam int CPU_BYTES = 24;
    localparam int SND_BYTES = 8;
    localparam int SPACING   = 4;
    localparam int HOLD      = 16;

    logic        clk_49m;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr_cpu;
    logic        dl_wr_snd;
    logic        core_reset;
    logic        rom_ok;
    logic        rom_err;
    logic [7:0]  checksum;

    typedef struct {
        logic        snd;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_cpu;
        logic        exp_snd;
        logic [24:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cpu_strobes = 0;
    int         snd_strobes = 0;
    int         last_strobe = -1;
    int         min_gap = 1000;
    logic [7:0] model_sum = 8'h00;
    exp_t       expq[$];
    vec_t       vecs[9];

    ioctl_rom_sequencer #(
        .CPU_ROM_BYTES(CPU_BYTES),
        .SND_ROM_BYTES(SND_BYTES),
        .WR_SPACING(SPACING),
        .RESET_HOLD(HOLD),
        .EXPECTED_SUM(8'h00)
    ) dut (
        .clk_49m(clk_49m),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .dl_wr_cpu(dl_wr_cpu),
        .dl_wr_snd(dl_wr_snd),
        .core_reset(core_reset),
        .rom_ok(rom_ok),
        .rom_err(rom_err),
        .checksum(checksum)
    );

    initial clk_49m = 1'b0;
    always #10 clk_49m = ~clk_49m;

    always @(posedge clk_49m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard: every output strobe must match the oldest expected write and respect the spacing.
    always @(negedge clk_49m) begin
        exp_t e;
        if (reset && (dl_wr_cpu || dl_wr_snd)) begin
            checkOutput("strobe_onehot", 32'(dl_wr_cpu & dl_wr_snd), 32'd0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected no strobe", dl_addr, dl_data);
            end else begin
                e = expq.pop_front();
                checkOutput("strobe_snd", 32'(dl_wr_snd), 32'(e.snd));
                checkOutput("strobe_addr", 32'(dl_addr), 32'(e.addr));
                checkOutput("strobe_data", 32'(dl_data), 32'(e.data));
                model_sum = model_sum + e.data;
            end
            if (last_strobe >= 0) begin
                checks++;
                if (cyc - last_strobe < SPACING) begin
                    errors++;
                    $display("[TB] FAIL strobe_gap: got %0d cycles, expected at least %0d", cyc - last_strobe, SPACING);
                end
                if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
            end
            last_strobe = cyc;
            if (dl_wr_cpu) cpu_strobes++;
            if (dl_wr_snd) snd_strobes++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data,
                                 input bit expect_pop);
        exp_t e;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_data  = data;
        ioctl_wr    = 1'b1;
        if (expect_pop) begin
            e.snd  = (idx == 8'd1);
            e.addr = addr;
            e.data = data;
            expq.push_back(e);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic startDownload();
        ioctl_download = 1'b1;
        model_sum      = 8'h00;
        cpu_strobes    = 0;
        snd_strobes    = 0;
        tick();
        tick();
    endtask

    // Download drop seen at the next edge, one cycle DRAIN with an empty FIFO, HOLD counts down then releases.
    task automatic waitRelease(input string name);
        int start;
        int n;
        start          = cyc;
        n              = 0;
        ioctl_download = 1'b0;
        while (core_reset && n < 200) begin
            tick();
            n++;
        end
        if (core_reset) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got core_reset=1, expected release", name);
        end else begin
            checkOutput({name, "_delay"}, 32'(cyc - start), 32'(HOLD + 3));
        end
    endtask

    task automatic pacedDownload(input bit mix_junk);
        for (int i = 0; i < CPU_BYTES; i++) begin
            applyStimulus(8'd0, 25'(i), 8'(i * 7 + 1), 1'b1);
            idle(7);
            if (mix_junk && (i % 5 == 0)) begin
                applyStimulus(8'd3, 25'(i), 8'hEE, 1'b0);
                idle(7);
            end
        end
        for (int i = 0; i < SND_BYTES; i++) begin
            applyStimulus(8'd1, 25'(i), 8'(i * 13 + 5), 1'b1);
            idle(7);
        end
    endtask

    task automatic checkGoodDownload(input string name);
        checkOutput({name, "_cpu_cnt"}, 32'(cpu_strobes), 32'(CPU_BYTES));
        checkOutput({name, "_snd_cnt"}, 32'(snd_strobes), 32'(SND_BYTES));
`ifdef DL_CHECKSUM_EN
        checkOutput({name, "_rom_ok"}, 32'(rom_ok), 32'(model_sum == 8'h00));
        checkOutput({name, "_rom_err"}, 32'(rom_err), 32'(model_sum != 8'h00));
        checkOutput({name, "_checksum"}, 32'(checksum), 32'(model_sum));
`else
        checkOutput({name, "_rom_ok"}, 32'(rom_ok), 32'd1);
        checkOutput({name, "_rom_err"}, 32'(rom_err), 32'd0);
        checkOutput({name, "_checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    initial begin
        int k;
        int guard;
        int released;
        bit wait_prev;

        vecs[0] = '{8'd0, 25'd5,  8'hA5, 1'b1, 1'b0, 25'd5,  8'hA5, 1'b0};
        vecs[1] = '{8'd1, 25'd3,  8'h3C, 1'b0, 1'b1, 25'd3,  8'h3C, 1'b0};
        vecs[2] = '{8'd3, 25'd7,  8'hFF, 1'b0, 1'b0, 25'd3,  8'h3C, 1'b0};
        vecs[3] = '{8'd0, 25'd23, 8'h11, 1'b1, 1'b0, 25'd23, 8'h11, 1'b0};
        vecs[4] = '{8'd1, 25'd7,  8'hE7, 1'b0, 1'b1, 25'd7,  8'hE7, 1'b0};
        vecs[5] = '{8'd2, 25'd1,  8'h55, 1'b0, 1'b0, 25'd7,  8'hE7, 1'b0};
        vecs[6] = '{8'd0, 25'd24, 8'h99, 1'b0, 1'b0, 25'd7,  8'hE7, 1'b1};
        vecs[7] = '{8'd1, 25'd8,  8'h42, 1'b0, 1'b0, 25'd7,  8'hE7, 1'b1};
        vecs[8] = '{8'd0, 25'd0,  8'h01, 1'b1, 1'b0, 25'd0,  8'h01, 1'b1};

        reset          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_data     = 8'd0;
        ioctl_wr       = 1'b0;
        idle(3);
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("rst_strobes", 32'({dl_wr_cpu, dl_wr_snd}), 32'd0);
        checkOutput("rst_addr", 32'(dl_addr), 32'd0);
        checkOutput("rst_data", 32'(dl_data), 32'd0);
        checkOutput("rst_flags", 32'({rom_ok, rom_err}), 32'd0);
        checkOutput("rst_checksum", 32'(checksum), 32'd0);

        reset = 1'b1;
        idle(100);
        checkOutput("idle_core_reset", 32'(core_reset), 32'd1);
        checkOutput("idle_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("idle_rom_ok", 32'(rom_ok), 32'd0);

        $display("[TB] table-driven vectors");
        startDownload();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].idx, vecs[i].addr, vecs[i].data, vecs[i].exp_cpu | vecs[i].exp_snd);
            tick();
            checkOutput($sformatf("vec%0d_cpu", i), 32'(dl_wr_cpu), 32'(vecs[i].exp_cpu));
            checkOutput($sformatf("vec%0d_snd", i), 32'(dl_wr_snd), 32'(vecs[i].exp_snd));
            checkOutput($sformatf("vec%0d_addr", i), 32'(dl_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d_data", i), 32'(dl_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_err", i), 32'(rom_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_core_reset", i), 32'(core_reset), 32'd1);
            idle(6);
        end
        waitRelease("bad_dl");
        checkOutput("bad_dl_rom_ok", 32'(rom_ok), 32'd0);
        checkOutput("bad_dl_rom_err", 32'(rom_err), 32'd1);

        $display("[TB] paced full download with foreign index bytes");
        startDownload();
        checkOutput("load_clears_err", 32'(rom_err), 32'd0);
        checkOutput("load_core_reset", 32'(core_reset), 32'd1);
        pacedDownload(1'b1);
        waitRelease("paced");
        checkGoodDownload("paced");

        $display("[TB] back-to-back writes honouring wait");
        startDownload();
        min_gap   = 1000;
        wait_prev = 1'b0;
        k         = 0;
        guard     = 0;
        while (k < CPU_BYTES + SND_BYTES && guard < 2000) begin
            if (!wait_prev) begin
                ioctl_index = (k < CPU_BYTES) ? 8'd0 : 8'd1;
                ioctl_addr  = (k < CPU_BYTES) ? 25'(k) : 25'(k - CPU_BYTES);
                ioctl_data  = 8'(k * 29 + 3);
                ioctl_wr    = 1'b1;
                expq.push_back('{ioctl_index == 8'd1, ioctl_addr, ioctl_data});
                k++;
            end else begin
                ioctl_wr = 1'b0;
            end
            wait_prev = ioctl_wait;
            tick();
            guard++;
        end
        ioctl_wr = 1'b0;
        checkOutput("burst_all_sent", 32'(k), 32'(CPU_BYTES + SND_BYTES));
        idle(20);
        checkOutput("burst_min_gap", 32'(min_gap), 32'(SPACING));
        checkOutput("burst_no_drop", 32'(rom_err), 32'd0);
        waitRelease("burst");
        checkGoodDownload("burst");

        $display("[TB] overflow drop, drain after download drop, reassert during hold");
        startDownload();
        for (int a = 0; a < 4; a++) begin
            ioctl_index = 8'd0;
            ioctl_addr  = 25'(a);
            ioctl_data  = 8'(8'h80 + a);
            ioctl_wr    = 1'b1;
            if (a < 3) expq.push_back('{1'b0, 25'(a), 8'(8'h80 + a)});
            tick();
        end
        ioctl_wr = 1'b0;
        checkOutput("full_drop_err", 32'(rom_err), 32'd1);
        checkOutput("full_wait", 32'(ioctl_wait), 32'd1);
        ioctl_download = 1'b0;
        idle(11);
        checkOutput("drain_all", 32'(expq.size()), 32'd0);
        checkOutput("hold_core_reset", 32'(core_reset), 32'd1);
        checkOutput("hold_rom_ok", 32'(rom_ok), 32'd0);
        checkOutput("hold_rom_err", 32'(rom_err), 32'd1);
        ioctl_download = 1'b1;
        model_sum      = 8'h00;
        cpu_strobes    = 0;
        snd_strobes    = 0;
        released       = 0;
        repeat (30) begin
            tick();
            if (!core_reset) released++;
        end
        checkOutput("reassert_core_reset", 32'(released), 32'd0);
        checkOutput("reassert_err_cleared", 32'(rom_err), 32'd0);
        pacedDownload(1'b0);
        waitRelease("restart");
        checkGoodDownload("restart");

        $display("[TB] reset in the middle of a download");
        startDownload();
        applyStimulus(8'd0, 25'd9, 8'h5A, 1'b0);
        ioctl_index = 8'd0;
        ioctl_addr  = 25'd10;
        ioctl_data  = 8'h5B;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr       = 1'b0;
        reset          = 1'b0;
        ioctl_download = 1'b0;
        #2;
        checkOutput("midrst_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("midrst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("midrst_addr", 32'(dl_addr), 32'd0);
        idle(3);
        reset = 1'b1;
        idle(20);
        checkOutput("midrst_idle_reset", 32'(core_reset), 32'd1);
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioctl_rom_sequencer.md
Name: ioctl_rom_sequencer

Overview:
- Sits directly upstream of the Tutankham core, between the MiSTer HPS ioctl download stream and the core's ROM-write and reset inputs.
- Buffers and paces incoming ROM bytes, routes them by ioctl index to the CPU-board or sound-board write strobes, and applies back-pressure through ioctl_wait.
- Holds the core in reset until a complete download has finished and settled.
- Reports download integrity: byte counts against expected sizes, plus an optional checksum.

Parameters:
- CPU_ROM_BYTES, 61440: required byte count for index 0 (main CPU programme and bank ROMs).
- SND_ROM_BYTES, 8192: required byte count for index 1 (sound ROM).
- WR_SPACING, 4: minimum clk_49m cycles between successive output write strobes; legal range 2–15.
- RESET_HOLD, 16: cycles core_reset stays high after the write buffer drains.
- EXPECTED_SUM, 8'h00: expected 8-bit checksum; used only when DL_CHECKSUM_EN is defined.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz.
- reset  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  HPS download-active flag.
- ioctl_index  in  8  download target index.
- ioctl_addr  in  25  byte address within the current index.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_wait  out  1  back-pressure to the HPS.
- dl_addr  out  25  buffered write address.
- dl_data  out  8  buffered write data.
- dl_wr_cpu  out  1  one-cycle write strobe for index 0.
- dl_wr_snd  out  1  one-cycle write strobe for index 1.
- core_reset  out  1  active-high reset to the core.
- rom_ok  out  1  last download was complete and valid.
- rom_err  out  1  sticky error from the last download.
- checksum  out  8  running 8-bit sum of accepted bytes.

Behaviour:
- Reset (reset low, asynchronous):
  - State is IDLE; FIFO is empty; counters, checksum and spacing timer are cleared.
  - dl_addr and dl_data are 0; dl_wr_cpu and dl_wr_snd are 0; ioctl_wait is 0.
  - core_reset is 1; rom_ok and rom_err are 0.
- State machine:
  - IDLE: core held in reset. ioctl_download=1 moves to LOAD.
  - LOAD: enqueue writes. ioctl_download falling moves to DRAIN.
  - DRAIN: pop until the FIFO is empty, then load the hold counter with RESET_HOLD and move to HOLD.
  - HOLD: count down; at 0 move to RUN.
  - RUN: core_reset=0. ioctl_download=1 moves to LOAD.
- Entering LOAD from any state:
  - Clears byte counters, checksum, rom_ok and rom_err.
  - Forces core_reset=1 in the same cycle the state registers.
- Accepting writes:
  - A write is accepted only when ioctl_wr=1 while in LOAD.
  - ioctl_wr in any other state is ignored.
  - Index 0 and index 1 are enqueued as {index bit, addr, data}.
  - Any other index is discarded silently, with no error.
- Range checks:
  - Index 0 with addr >= CPU_ROM_BYTES is discarded and sets rom_err.
  - Index 1 with addr >= SND_ROM_BYTES is discarded and sets rom_err.
- FIFO:
  - 2 entries.
  - ioctl_wait is registered and equals (occupancy >= 1), so the second slot absorbs the HPS one-cycle wait latency.
  - A write arriving while occupancy is 2 is dropped and sets rom_err.
  - A push and a pop in the same cycle are legal; occupancy is unchanged.
- Output pacing:
  - A pop happens when the FIFO is non-empty and the spacing timer is 0.
  - On a pop, dl_addr and dl_data are registered, exactly one of dl_wr_cpu or dl_wr_snd pulses for 1 cycle, and the timer loads WR_SPACING-1.
  - Latency from an accepted ioctl_wr into an empty FIFO with the timer at 0 to the strobe is 2 cycles.
  - dl_addr and dl_data hold their values between strobes.
- Counting:
  - Separate per-index byte counters, 17 bits, saturating; they increment on each pop.
  - checksum = checksum + dl_data on each pop, mod 256.
- Completion:
  - On DRAIN→HOLD, rom_ok = !rom_err && cpu_count == CPU_ROM_BYTES && snd_count == SND_ROM_BYTES.
  - rom_ok and rom_err persist through RUN until the next download.
- Boundary cases:
  - ioctl_download dropping while the FIFO holds entries: all entries still drain in order.
  - ioctl_download reasserting during DRAIN or HOLD: go to LOAD; entries already queued still drain, but counters restart from zero.
  - reset mid-download: the FIFO is flushed and state returns to IDLE.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined: the rom_ok equation additionally requires checksum == EXPECTED_SUM. A mismatch sets rom_err at DRAIN→HOLD.
- Undefined: the checksum output is tied to 8'h00, no summing logic is built, and EXPECTED_SUM is ignored.

Test Plan:
- Reset, then idle for 100 cycles → core_reset=1, ioctl_wait=0, no strobes, rom_ok=0.
- Download index 0 of 61440 bytes, then index 1 of 8192 bytes, with ioctl_wr every 8 cycles → exactly 61440 dl_wr_cpu and 8192 dl_wr_snd pulses with matching addr/data; rom_ok=1; core_reset falls 16 cycles after the last strobe plus the drain.
- Back-to-back ioctl_wr every cycle, with the HPS model honouring ioctl_wait at one-cycle latency → no drops, strobe spacing exactly 4 cycles, rom_err=0.
- Index 0 write at addr 61440 (0xF000) → no strobe, rom_err=1, rom_ok=0 after the download ends.
- Index 3 bytes mixed into a valid download → ignored, rom_ok=1.
- Drive ioctl_wr with the FIFO full and wait ignored → byte dropped and rom_err=1. Then reassert ioctl_download during HOLD → core_reset stays 1 and counters restart.
